// File: rtl/program_loader_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding,
// default widths shared with fetch/imem, and the frame checksum add.
package program_loader_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

  // Running checksum step; wraps modulo 2^DATA_W.
  function automatic logic [DATA_W_DEF-1:0] csum_add(
    input logic [DATA_W_DEF-1:0] acc,
    input logic [DATA_W_DEF-1:0] val
  );
    return acc + val;
  endfunction

endpackage

// File: rtl/program_loader.sv
// Receives a LEN/payload/CSUM frame from the host, writes the payload into
// instruction memory from address 0 and releases the core on a good frame.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [DATA_W-1:0] byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   bytes_loaded
);

  localparam logic [ADDR_W:0] FULL_FRAME = {1'b1, {ADDR_W{1'b0}}};

  state_t            state;
  state_t            next_state;
  logic [ADDR_W:0]   remaining;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] sum;
  logic              xfer;

  assign xfer = byte_valid && byte_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  // done/error/core_hold follow the state directly, so they clear together on start.
  always_comb begin
    next_state = state;
    byte_ready = 1'b0;
    case (state)
      ST_IDLE: if (start) next_state = ST_LEN;
      ST_LEN: begin
        byte_ready = 1'b1;
        if (byte_valid) next_state = ST_DATA;
      end
      ST_DATA: begin
        byte_ready = 1'b1;
        if (byte_valid && remaining == (ADDR_W+1)'(1)) next_state = ST_CSUM;
      end
      ST_CSUM: begin
        byte_ready = 1'b1;
        if (byte_valid) next_state = (byte_data == sum) ? ST_DONE : ST_ERR;
      end
      ST_DONE, ST_ERR: if (start) next_state = ST_LEN;
      default: next_state = ST_IDLE;
    endcase
    done      = (state == ST_DONE);
    error     = (state == ST_ERR);
    core_hold = (state != ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we       <= 1'b0;
      mem_waddr    <= '0;
      mem_wdata    <= '0;
      remaining    <= '0;
      ptr          <= '0;
      sum          <= '0;
      bytes_loaded <= '0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          sum          <= '0;
          bytes_loaded <= '0;
        end
        ST_LEN: begin
          if (xfer) begin
            remaining <= (byte_data[ADDR_W-1:0] == '0) ? FULL_FRAME
                                                       : {1'b0, byte_data[ADDR_W-1:0]};
            ptr       <= '0;
          end
        end
        ST_DATA: begin
          if (xfer) begin
            mem_we       <= 1'b1;
            mem_waddr    <= ptr;
            mem_wdata    <= byte_data;
            ptr          <= ptr + ADDR_W'(1);
            bytes_loaded <= bytes_loaded + (ADDR_W+1)'(1);
            sum          <= csum_add(sum, byte_data);
            remaining    <= remaining - (ADDR_W+1)'(1);
          end
        end
        ST_DONE, ST_ERR: begin
          if (start) begin
            sum          <= '0;
            bytes_loaded <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader.
module tb_program_loader;

  logic       clk;
  logic       reset;
  logic       start;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;
  logic       mem_we;
  logic [7:0] mem_waddr;
  logic [7:0] mem_wdata;
  logic       core_hold;
  logic       done;
  logic       error;
  logic [8:0] bytes_loaded;

  int checks = 0;
  int errors = 0;

  program_loader dut (
    .clk(clk), .reset(reset), .start(start),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .core_hold(core_hold), .done(done), .error(error),
    .bytes_loaded(bytes_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " byte_ready"},   32'(byte_ready),   32'd0);
    check({tag, " mem_we"},       32'(mem_we),       32'd0);
    check({tag, " mem_waddr"},    32'(mem_waddr),    32'd0);
    check({tag, " mem_wdata"},    32'(mem_wdata),    32'd0);
    check({tag, " core_hold"},    32'(core_hold),    32'd1);
    check({tag, " done"},         32'(done),         32'd0);
    check({tag, " error"},        32'(error),        32'd0);
    check({tag, " bytes_loaded"}, 32'(bytes_loaded), 32'd0);
  endtask

  task automatic check_status(input string tag, input logic d, input logic e,
                              input logic h, input logic [8:0] n);
    check({tag, " done"},         32'(done),         32'(d));
    check({tag, " error"},        32'(error),        32'(e));
    check({tag, " core_hold"},    32'(core_hold),    32'(h));
    check({tag, " bytes_loaded"}, 32'(bytes_loaded), 32'(n));
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Presents one byte for exactly one edge and checks the write that follows it.
  task automatic send_byte(input logic [7:0] b, input logic exp_we,
                           input logic [7:0] exp_addr);
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    check("byte_ready", 32'(byte_ready), 32'd1);
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    check("mem_we", 32'(mem_we), 32'(exp_we));
    if (exp_we) begin
      check("mem_waddr", 32'(mem_waddr), 32'(exp_addr));
      check("mem_wdata", 32'(mem_wdata), 32'(b));
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      check("gap mem_we", 32'(mem_we), 32'd0);
    end
  endtask

  initial begin
    logic [7:0] gap_frame [6];
    reset      = 1'b1;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    reset = 1'b0;

    // Good 3-byte frame, no gaps
    pulse_start();
    send_byte(8'h03, 1'b0, 8'h00);
    send_byte(8'h11, 1'b1, 8'h00);
    send_byte(8'h22, 1'b1, 8'h01);
    send_byte(8'h33, 1'b1, 8'h02);
    send_byte(8'h66, 1'b0, 8'h00);
    check_status("frame1", 1'b1, 1'b0, 1'b0, 9'd3);
    check("frame1 byte_ready", 32'(byte_ready), 32'd0);

    // Bad checksum (correct value would be 65)
    pulse_start();
    check_status("restart", 1'b0, 1'b0, 1'b1, 9'd0);
    send_byte(8'h02, 1'b0, 8'h00);
    send_byte(8'hAA, 1'b1, 8'h00);
    send_byte(8'hBB, 1'b1, 8'h01);
    send_byte(8'h00, 1'b0, 8'h00);
    check_status("badcsum", 1'b0, 1'b1, 1'b1, 9'd2);

    pulse_start();
    check_status("err restart", 1'b0, 1'b0, 1'b1, 9'd0);
    send_byte(8'h01, 1'b0, 8'h00);
    send_byte(8'h42, 1'b1, 8'h00);
    send_byte(8'h42, 1'b0, 8'h00);
    check_status("recover", 1'b1, 1'b0, 1'b0, 9'd1);

    // Full 256-byte frame, payload 00..FF, checksum 0x7F80 mod 256 = 80
    pulse_start();
    send_byte(8'h00, 1'b0, 8'h00);
    for (int i = 0; i < 256; i++) send_byte(8'(i), 1'b1, 8'(i));
    check_status("full pre-csum", 1'b0, 1'b0, 1'b1, 9'd256);
    send_byte(8'h80, 1'b0, 8'h00);
    check_status("full", 1'b1, 1'b0, 1'b0, 9'd256);

    // Random gaps; checksum 01+02+03+FF = 105 -> 05
    gap_frame[0] = 8'h04; gap_frame[1] = 8'h01; gap_frame[2] = 8'h02;
    gap_frame[3] = 8'h03; gap_frame[4] = 8'hFF; gap_frame[5] = 8'h05;
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      idle_cycles(int'($urandom_range(0, 5)));
      send_byte(gap_frame[i], (i >= 1 && i <= 4), 8'(i - 1));
    end
    check_status("gaps", 1'b1, 1'b0, 1'b0, 9'd4);

    // Reset after two payload bytes
    pulse_start();
    send_byte(8'h05, 1'b0, 8'h00);
    send_byte(8'h10, 1'b1, 8'h00);
    send_byte(8'h20, 1'b1, 8'h01);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_reset_values("midreset");
    reset = 1'b0;
    @(negedge clk);
    check("midreset idle ready", 32'(byte_ready), 32'd0);
    pulse_start();
    send_byte(8'h02, 1'b0, 8'h00);
    send_byte(8'h07, 1'b1, 8'h00);
    send_byte(8'h08, 1'b1, 8'h01);
    send_byte(8'h0F, 1'b0, 8'h00);
    check_status("after reset", 1'b1, 1'b0, 1'b0, 9'd2);

    // Start pulse during DATA is ignored
    pulse_start();
    send_byte(8'h03, 1'b0, 8'h00);
    send_byte(8'h01, 1'b1, 8'h00);
    pulse_start();
    check("start in DATA ready", 32'(byte_ready), 32'd1);
    check("start in DATA count", 32'(bytes_loaded), 32'd1);
    send_byte(8'h02, 1'b1, 8'h01);
    send_byte(8'h03, 1'b1, 8'h02);
    send_byte(8'h06, 1'b0, 8'h00);
    check_status("start ignored", 1'b1, 1'b0, 1'b0, 9'd3);

    // Host bytes in DONE are refused
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      byte_valid = 1'b1;
      byte_data  = 8'h55;
      check("done byte_ready", 32'(byte_ready), 32'd0);
      @(posedge clk);
      #1;
      check("done mem_we", 32'(mem_we), 32'd0);
    end
    byte_valid = 1'b0;
    check_status("done hold", 1'b1, 1'b0, 1'b0, 9'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
